// File: rtl/track_stream_tx.sv
// Track stream transmitter: per-lane FIFOs feed lock-step NLANES-wide beats to the
// jet finder, closing each event with an end-of-event beat and truncating long events.
module track_stream_tx #(
  parameter int NLANES  = 18,
  parameter int W       = 96,
  parameter int DEPTH   = 16,
  parameter int MAX_TRK = 24
) (
  input  logic                s_clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [NLANES-1:0]   wr_en,
  input  logic [NLANES*W-1:0] wr_data,
  output logic [NLANES-1:0]   wr_full,
  output logic [NLANES*W-1:0] track_out,
  output logic                vld_out,
  input  logic                rdy_in,
  output logic                eoe_out,
  output logic [11:0]         evt_cnt,
  output logic                wr_ovf,
  output logic                trk_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(MAX_TRK + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [BW-1:0] MAX_C   = BW'(MAX_TRK);

  typedef enum logic [0:0] {ST_STREAM = 1'b0, ST_DRAIN = 1'b1} state_e;

  logic [W-1:0]        mem_q    [NLANES][DEPTH];
  logic [AW-1:0]       rd_ptr_q [NLANES];
  logic [AW-1:0]       wr_ptr_q [NLANES];
  logic [CW-1:0]       cnt_q    [NLANES];
  state_e              state_q;
  logic [BW-1:0]       beat_cnt_q;
  logic [NLANES*W-1:0] track_q;
  logic                vld_q;
  logic                eoe_q;
  logic [11:0]         evt_cnt_q;
  logic                wr_ovf_q;
  logic                trk_ovf_q;

  logic [NLANES-1:0]   empty_s, head_nz_s, next_nz_s, wr_ok_s, pop_s;
  logic [NLANES*W-1:0] track_d;
  logic [BW-1:0]       beat_inc_s;
  logic                may_load_s, all_ne_s, any_nz_s;
  logic                launch_data_s, launch_end_s, go_drain_s, go_stream_s;

  // Per-lane FIFO status and the head / next-after-head words
  always_comb begin
    for (int k = 0; k < NLANES; k++) begin
      empty_s[k]        = (cnt_q[k] == {CW{1'b0}});
      head_nz_s[k]      = !empty_s[k] && (mem_q[k][rd_ptr_q[k]] != {W{1'b0}});
      next_nz_s[k]      = (cnt_q[k] > CW'(1)) &&
                          (mem_q[k][rd_ptr_q[k] + AW'(1)] != {W{1'b0}});
      wr_full[k]        = (cnt_q[k] == DEPTH_C);
      wr_ok_s[k]        = wr_en[k] && !wr_full[k];
      track_d[k*W +: W] = head_nz_s[k] ? mem_q[k][rd_ptr_q[k]] : {W{1'b0}};
    end
  end

  // Launch / drain decision
  always_comb begin
    may_load_s    = !vld_q || rdy_in;
    all_ne_s      = ~|empty_s;
    any_nz_s      = |head_nz_s;
    beat_inc_s    = beat_cnt_q + BW'(1);
    pop_s         = {NLANES{1'b0}};
    launch_data_s = 1'b0;
    launch_end_s  = 1'b0;
    go_drain_s    = 1'b0;
    go_stream_s   = 1'b0;
    case (state_q)
      ST_STREAM: begin
        // A track surfacing in a lane that was empty when the last allowed beat
        // left is caught here, before it can leak out as an extra beat.
        if ((beat_cnt_q == MAX_C) && any_nz_s) begin
          go_drain_s = 1'b1;
        end else if (start && may_load_s && all_ne_s) begin
          if (any_nz_s) begin
            launch_data_s = 1'b1;
            pop_s         = head_nz_s;
            go_drain_s    = (beat_inc_s == MAX_C) && (|(head_nz_s & next_nz_s));
          end else begin
            launch_end_s = 1'b1;
            pop_s        = {NLANES{1'b1}};
          end
        end else begin
          pop_s = {NLANES{1'b0}};
        end
      end
      ST_DRAIN: begin
        pop_s       = head_nz_s;
        go_stream_s = all_ne_s && !any_nz_s;
      end
      default: begin
        go_stream_s = 1'b1;
      end
    endcase
  end

  // FIFO storage; pointers and counts decide which entries are live
  always_ff @(posedge s_clk) begin
    for (int k = 0; k < NLANES; k++) begin
      if (wr_ok_s[k]) begin
        mem_q[k][wr_ptr_q[k]] <= wr_data[k*W +: W];
      end
    end
  end

  // FIFO pointers, output register, counters and state
  always_ff @(posedge s_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NLANES; k++) begin
        rd_ptr_q[k] <= {AW{1'b0}};
        wr_ptr_q[k] <= {AW{1'b0}};
        cnt_q[k]    <= {CW{1'b0}};
      end
      state_q    <= ST_STREAM;
      beat_cnt_q <= {BW{1'b0}};
      track_q    <= {(NLANES*W){1'b0}};
      vld_q      <= 1'b0;
      eoe_q      <= 1'b0;
      evt_cnt_q  <= 12'd0;
      wr_ovf_q   <= 1'b0;
      trk_ovf_q  <= 1'b0;
    end else begin
      for (int k = 0; k < NLANES; k++) begin
        if (wr_ok_s[k]) wr_ptr_q[k] <= wr_ptr_q[k] + AW'(1);
        if (pop_s[k])   rd_ptr_q[k] <= rd_ptr_q[k] + AW'(1);
        cnt_q[k] <= cnt_q[k] + CW'(wr_ok_s[k]) - CW'(pop_s[k]);
      end
      if (launch_data_s || launch_end_s) begin
        track_q <= launch_end_s ? {(NLANES*W){1'b0}} : track_d;
        vld_q   <= 1'b1;
        eoe_q   <= launch_end_s;
      end else if (vld_q && rdy_in) begin
        track_q <= {(NLANES*W){1'b0}};
        vld_q   <= 1'b0;
        eoe_q   <= 1'b0;
      end
      if (launch_data_s) begin
        beat_cnt_q <= beat_inc_s;
      end else if (launch_end_s) begin
        beat_cnt_q <= {BW{1'b0}};
      end
      if (launch_end_s) evt_cnt_q <= evt_cnt_q + 12'd1;
      if (|(wr_en & wr_full)) wr_ovf_q <= 1'b1;
      if (go_drain_s) begin
        state_q   <= ST_DRAIN;
        trk_ovf_q <= 1'b1;
      end else if (go_stream_s) begin
        state_q <= ST_STREAM;
      end
    end
  end

  assign track_out = track_q;
  assign vld_out   = vld_q;
  assign eoe_out   = eoe_q;
  assign evt_cnt   = evt_cnt_q;
  assign wr_ovf    = wr_ovf_q;
  assign trk_ovf   = trk_ovf_q;
endmodule

// File: tb/tb_track_stream_tx.sv
// Scoreboard bench for track_stream_tx: per-event expected beats are queued when the
// lane words are loaded and compared as each beat is accepted downstream.
module tb_track_stream_tx;
  localparam int NLANES  = 18;
  localparam int W       = 96;
  localparam int MAX_TRK = 24;

  typedef struct packed {
    logic [NLANES*W-1:0] trk;
    logic                eoe;
  } beat_t;

  logic                s_clk, reset_n, start, rdy_in;
  logic [NLANES-1:0]   wr_en, wr_full;
  logic [NLANES*W-1:0] wr_data, track_out;
  logic                vld_out, eoe_out, wr_ovf, trk_ovf;
  logic [11:0]         evt_cnt;

  int           n_chk = 0;
  int           n_err = 0;
  int           rdy_mode = 0;
  int           ntrk [NLANES];
  beat_t        sb [$];
  logic [W-1:0] lq [NLANES][$];

  track_stream_tx dut (
    .s_clk(s_clk), .reset_n(reset_n), .start(start), .wr_en(wr_en),
    .wr_data(wr_data), .wr_full(wr_full), .track_out(track_out),
    .vld_out(vld_out), .rdy_in(rdy_in), .eoe_out(eoe_out),
    .evt_cnt(evt_cnt), .wr_ovf(wr_ovf), .trk_ovf(trk_ovf)
  );

  initial s_clk = 1'b0;
  always #5 s_clk = ~s_clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_word(input int tag, input int lane, input int idx);
    logic [W-1:0] w;
    w          = {W{1'b0}};
    w[95:88]   = 8'hA5;
    w[31:24]   = tag[7:0];
    w[23:16]   = lane[7:0];
    w[15:0]    = idx[15:0];
    return w;
  endfunction

  // rdy_mode: 0 = always ready, 1 = toggle every cycle, 2 = never ready
  task automatic tick();
    @(posedge s_clk);
    #1;
    if (rdy_mode == 1) rdy_in = ~rdy_in;
    else rdy_in = (rdy_mode == 0);
  endtask

  task automatic monitor();
    bit                  hv;
    logic [NLANES*W-1:0] ht;
    logic                he;
    beat_t               e;
    int                  nb;
    hv = 1'b0; ht = '0; he = 1'b0; nb = 0;
    forever begin
      @(negedge s_clk);
      if (!reset_n) begin
        hv = 1'b0;
      end else begin
        if (hv) begin
          check("hold_trk", 128'(track_out == ht), 128'(1));
          check("hold_vld", 128'(vld_out), 128'(1));
          check("hold_eoe", 128'(eoe_out), 128'(he));
        end
        hv = vld_out && !rdy_in;
        ht = track_out;
        he = eoe_out;
        if (vld_out && rdy_in) begin
          if (sb.size() == 0) begin
            check("extra_beat", 128'(1), 128'(0));
          end else begin
            e = sb.pop_front();
            for (int k = 0; k < NLANES; k++)
              check($sformatf("beat%0d_lane%0d", nb, k),
                    128'(track_out[k*W +: W]), 128'(e.trk[k*W +: W]));
            check($sformatf("beat%0d_eoe", nb), 128'(eoe_out), 128'(e.eoe));
            nb++;
          end
        end
      end
    end
  endtask

  // Queue lane words (with terminators) and the beats the event must produce
  task automatic load_event(input int tag);
    int    nb;
    beat_t b;
    nb = 0;
    for (int k = 0; k < NLANES; k++) begin
      if (ntrk[k] > nb) nb = ntrk[k];
      for (int i = 1; i <= ntrk[k]; i++) lq[k].push_back(mk_word(tag, k, i));
      lq[k].push_back({W{1'b0}});
    end
    if (nb > MAX_TRK) nb = MAX_TRK;
    for (int bi = 0; bi < nb; bi++) begin
      b.eoe = 1'b0;
      for (int k = 0; k < NLANES; k++)
        b.trk[k*W +: W] = (bi < ntrk[k]) ? mk_word(tag, k, bi + 1) : {W{1'b0}};
      sb.push_back(b);
    end
    b.trk = '0;
    b.eoe = 1'b1;
    sb.push_back(b);
  endtask

  task automatic drive_writes();
    wr_en = '0;
    for (int k = 0; k < NLANES; k++) begin
      if (lq[k].size() > 0 && !wr_full[k]) begin
        wr_en[k]          = 1'b1;
        wr_data[k*W +: W] = lq[k].pop_front();
      end
    end
  endtask

  task automatic run_event(input int start_delay, input bit lat_chk);
    int cyc;
    bit busy;
    cyc  = 0;
    busy = 1'b1;
    while (busy) begin
      if (lat_chk && cyc == 1) check("latency_edge_t", 128'(vld_out), 128'(0));
      if (lat_chk && cyc == 2) check("latency_edge_t1", 128'(vld_out), 128'(1));
      drive_writes();
      start = (cyc >= start_delay);
      tick();
      cyc++;
      busy = (sb.size() > 0);
      for (int k = 0; k < NLANES; k++) if (lq[k].size() > 0) busy = 1'b1;
      if (cyc > 2000) begin
        check("timeout", 128'(1), 128'(0));
        busy = 1'b0;
      end
    end
    wr_en = '0;
    repeat (6) tick();
  endtask

  task automatic end_checks(input int exp_evt, input bit exp_trk);
    check("evt_cnt", 128'(evt_cnt), 128'(exp_evt));
    check("trk_ovf", 128'(trk_ovf), 128'(exp_trk));
    check("wr_ovf", 128'(wr_ovf), 128'(0));
    check("idle_vld", 128'(vld_out), 128'(0));
    check("sb_empty", 128'(sb.size()), 128'(0));
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    wr_en    = '0;
    start    = 1'b0;
    rdy_mode = 0;
    rdy_in   = 1'b1;
    sb.delete();
    for (int k = 0; k < NLANES; k++) lq[k].delete();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_trk"}, 128'(track_out == '0), 128'(1));
    check({tag, "_vld"}, 128'(vld_out), 128'(0));
    check({tag, "_eoe"}, 128'(eoe_out), 128'(0));
    check({tag, "_evt"}, 128'(evt_cnt), 128'(0));
    check({tag, "_full"}, 128'(wr_full), 128'(0));
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; rdy_in = 1'b1; wr_en = '0; wr_data = '0;
    fork
      monitor();
    join_none

    // Reset state
    #3;
    check_zero_outputs("rst_async");
    do_reset();
    check_zero_outputs("rst");
    check("rst_wr_ovf", 128'(wr_ovf), 128'(0));
    check("rst_trk_ovf", 128'(trk_ovf), 128'(0));

    // Three tracks in every lane
    for (int k = 0; k < NLANES; k++) ntrk[k] = 3;
    load_event(1);
    run_event(0, 1'b1);
    end_checks(1, 1'b0);

    // Uneven lanes: lane 0 has five, others two
    do_reset();
    for (int k = 0; k < NLANES; k++) ntrk[k] = 2;
    ntrk[0] = 5;
    load_event(2);
    run_event(0, 1'b0);
    end_checks(1, 1'b0);

    // Same with a toggling downstream ready
    do_reset();
    load_event(3);
    rdy_mode = 1;
    run_event(0, 1'b0);
    rdy_mode = 0;
    end_checks(1, 1'b0);

    // Over-length event in lane 4, prefilled before start
    do_reset();
    for (int k = 0; k < NLANES; k++) ntrk[k] = 0;
    ntrk[4] = 30;
    load_event(4);
    run_event(20, 1'b0);
    end_checks(1, 1'b1);

    // Lane 7 overflow with start held low
    do_reset();
    for (int i = 0; i < 16; i++) begin
      check($sformatf("full_early%0d", i), 128'(wr_full[7]), 128'(0));
      wr_en             = 18'h00080;
      wr_data[7*W +: W] = mk_word(5, 7, i + 1);
      tick();
    end
    wr_en = '0;
    check("full_after16", 128'(wr_full), 128'(18'h00080));
    check("ovf_before17", 128'(wr_ovf), 128'(0));
    wr_en = 18'h00080;
    wr_data[7*W +: W] = mk_word(5, 7, 17);
    tick();
    wr_en = '0;
    check("ovf_after17", 128'(wr_ovf), 128'(1));
    check("full_after17", 128'(wr_full[7]), 128'(1));
    check("no_beat_start0", 128'(vld_out), 128'(0));

    // Reset mid-event while a beat is being held
    do_reset();
    for (int k = 0; k < NLANES; k++) ntrk[k] = 3;
    load_event(6);
    rdy_mode = 2;
    rdy_in   = 1'b0;
    for (int c = 0; c < 10 && !vld_out; c++) begin
      drive_writes();
      start = 1'b1;
      tick();
    end
    wr_en = '0;
    check("pre_rst_vld", 128'(vld_out), 128'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check_zero_outputs("mid_rst");
    do_reset();
    load_event(7);
    run_event(0, 1'b1);
    end_checks(1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
